ahb_slave_arbiter: RTL and testbench
====================================

Name: ahb_slave_arbiter

Overview:
- Round-robin arbiter on the slave side of the generated AHB interconnect, one instance per slave port.
- Decides which master channel owns this slave's address bus.
- Drives the one-hot `sel` consumed directly downstream by the slave-side payload mux:
  - `sel_addr` for the address/control payload.
  - `sel_data` for data-phase payloads.
- Ownership changes only at burst boundaries, so a fixed-length burst is never split.

Parameters:
- CHANNEL_NUM, 2, number of master channels that can target this slave (≥2).
- ID_W, $clog2(CHANNEL_NUM), width of owner_id.

Ports:
- hclk  input  1  clock; all state updates on its rising edge.
- hreset  input  1  synchronous, active-high reset.
- hreq  input  CHANNEL_NUM  per-channel request; the master's decoder has selected this slave.
- htrans  input  CHANNEL_NUM x 2  per-channel HTRANS: 0 IDLE, 1 BUSY, 2 NONSEQ, 3 SEQ.
- hburst  input  CHANNEL_NUM x 3  per-channel HBURST: 0 SINGLE, 1 INCR, 2/3 4-beat, 4/5 8-beat, 6/7 16-beat.
- hready  input  1  HREADYOUT of this slave; 1 means the current beat completes at this edge.
- sel_addr  output  CHANNEL_NUM  one-hot address-phase select (owner), all-zero when no owner.
- sel_data  output  CHANNEL_NUM  one-hot data-phase select (sel_addr delayed by one accepted phase).
- owner_id  output  ID_W  binary index of current owner; valid when grant_valid=1.
- grant_valid  output  1  an owner exists (sel_addr nonzero).

Behaviour:
- All outputs are registered.
- Reset values (next edge with hreset=1):
  - sel_addr=0, sel_data=0, owner_id=0, grant_valid=0.
  - rr_ptr=0, rem=0, incr_mode=0, state IDLE.
  - Reset mid-burst abandons the burst; no partial state survives.
- States:
  - IDLE: no owner.
  - OWN: owner_id drives sel_addr.
- Accepted beat: edge with hready=1 and owner htrans ∈ {NONSEQ, SEQ}.
- Beat counter `rem`:
  - On an accepted NONSEQ: rem = burst_len − 1, with lengths SINGLE 1, 4-beat 4, 8-beat 8, 16-beat 16. For INCR set incr_mode=1 and rem=0.
  - On an accepted SEQ: rem = rem − 1, saturating at 0.
  - BUSY and hready=0 cycles: rem unchanged.
- Switch point: an edge with hready=1 where any of the following holds:
  - (a) state IDLE.
  - (b) owner htrans=IDLE.
  - (c) incr_mode=0, an accepted beat occurs, and rem after update =0.
  - (d) incr_mode=1, hreq[owner]=0, and owner htrans ≠ BUSY.
- No switch while hready=0. No switch while a fixed burst has rem>0, even if hreq[owner] drops.
- At a switch point:
  - Search requesters round-robin starting at (owner_id+1) mod CHANNEL_NUM when in OWN, or at rr_ptr when in IDLE. The old owner is considered last.
  - If a requester is found: state OWN, owner_id=winner, sel_addr=1<<winner, rr_ptr=(winner+1) mod N, incr_mode=0.
  - If no requester is found: state IDLE, sel_addr=0, grant_valid=0.
  - If the sole requester is the current owner: it is re-granted with no bubble.
- Single-cycle handover: the edge completing the last beat's address phase also moves sel_addr. The new owner's NONSEQ is visible to the mux in the very next cycle.
- sel_data update on each edge:
  - hready=1: sel_data = accepted-beat ? sel_addr(pre-edge) : 0.
  - hready=0: sel_data holds.
- This yields a data phase lagging the address phase by exactly one accepted phase, including across owner changes.
- Simultaneous events:
  - A switch and a NONSEQ accept on the same edge: the outgoing owner's beat is accounted in sel_data, and rem/incr_mode are reset for the new owner.
  - A non-owner hreq dropping before grant is simply not selected.
- Invariants:
  - sel_addr and sel_data are each zero or one-hot.
  - grant_valid == |sel_addr.
  - owner_id is stable whenever sel_addr is stable.

Test Plan:
- Reset then idle:
  - Stimulus: hreset high 2 cycles, hreq=00, hready=1.
  - Required: sel_addr=00, sel_data=00, grant_valid=0 throughout.
- Basic grant and data lag:
  - Stimulus: N=2, hreq=01, ch0 NONSEQ SINGLE, then IDLE.
  - Required: sel_addr=01 from edge 1; sel_data=01 exactly one cycle later, then 00 after the IDLE is accepted.
- Burst integrity with wait states:
  - Stimulus: ch0 INCR4 (NONSEQ, SEQ×3) with hready=0 for 2 cycles on beat 2; ch1 requests from cycle 1.
  - Required: sel_addr stays 01 through all 4 beats including stalls; switches to 10 on the edge accepting beat 4.
- Round-robin fairness:
  - Stimulus: N=4, hreq=1111, every master issues SINGLE.
  - Required: grants rotate 0,1,2,3,0 on consecutive switch points.
  - Stimulus: hreq=1010 starting from owner 1.
  - Required: next grant is 3, then 1.
- INCR release:
  - Stimulus: ch1 INCR, 5 SEQ beats, then hreq[1]=0 while ch0 requests.
  - Required: owner switches to 0 only on the edge where hreq[1]=0 and hready=1. A BUSY on that edge delays the switch.
- Reset mid-burst:
  - Stimulus: hreset asserted during beat 2 of an 8-beat burst.
  - Required: next edge gives sel_addr=00, sel_data=00, rr_ptr=0. After release, hreq=11 grants ch0.

Source files
------------

// File: rtl/ahb_slave_arbiter.sv
// Round-robin owner arbiter for one AHB slave port; drives one-hot address/data-phase mux selects.
// Latency: all outputs registered; ownership moves on the edge that completes the last address phase.
// Backpressure: hready=0 freezes ownership, beat count and data-phase select.
module ahb_slave_arbiter #(
  parameter int CHANNEL_NUM = 2,
  parameter int ID_W        = $clog2(CHANNEL_NUM)
) (
  input  logic                        hclk,
  input  logic                        hreset,
  input  logic [CHANNEL_NUM-1:0]      hreq,
  input  logic [CHANNEL_NUM-1:0][1:0] htrans,
  input  logic [CHANNEL_NUM-1:0][2:0] hburst,
  input  logic                        hready,
  output logic [CHANNEL_NUM-1:0]      sel_addr,
  output logic [CHANNEL_NUM-1:0]      sel_data,
  output logic [ID_W-1:0]             owner_id,
  output logic                        grant_valid
);

  localparam logic [1:0] TR_IDLE   = 2'd0;
  localparam logic [1:0] TR_BUSY   = 2'd1;
  localparam logic [1:0] TR_NONSEQ = 2'd2;
  localparam logic [2:0] BU_INCR   = 3'd1;

  typedef enum logic {ST_IDLE, ST_OWN} state_e;

  state_e                 state_q, state_d;
  logic [ID_W-1:0]        owner_q, owner_d;
  logic [ID_W-1:0]        rr_ptr_q, rr_ptr_d;
  logic [CHANNEL_NUM-1:0] sel_addr_q, sel_addr_d;
  logic [CHANNEL_NUM-1:0] sel_data_q, sel_data_d;
  logic                   grant_q, grant_d;
  logic [3:0]             rem_q, rem_d;
  logic                   incr_q, incr_d;

  logic [1:0]      own_trans;
  logic [2:0]      own_burst;
  logic            own_req;
  logic            beat_acc;
  logic [3:0]      burst_rem;
  logic [3:0]      rem_upd;
  logic            incr_upd;
  logic            switch_pt;
  logic [ID_W-1:0] start;
  logic [ID_W-1:0] winner;
  logic [ID_W-1:0] idx;
  logic            found;
  int              cand;

  // Next index with wrap at CHANNEL_NUM (works for non-power-of-two counts).
  function automatic logic [ID_W-1:0] wrap_inc(input logic [ID_W-1:0] v);
    return (int'(v) == CHANNEL_NUM - 1) ? '0 : v + ID_W'(1);
  endfunction

  assign own_trans = htrans[owner_q];
  assign own_burst = hburst[owner_q];
  assign own_req   = hreq[owner_q];
  // A beat is only accepted from a real owner; the stale owner_q in IDLE is ignored.
  assign beat_acc  = (state_q == ST_OWN) && hready && own_trans[1];

  // Remaining beats after a NONSEQ for fixed bursts; SINGLE and INCR both start at zero.
  always_comb begin
    case (own_burst)
      3'd2, 3'd3: burst_rem = 4'd3;
      3'd4, 3'd5: burst_rem = 4'd7;
      3'd6, 3'd7: burst_rem = 4'd15;
      default:    burst_rem = 4'd0;
    endcase
  end

  // Beat accounting for the current owner, before any ownership change is applied.
  always_comb begin
    rem_upd  = rem_q;
    incr_upd = incr_q;
    if (beat_acc) begin
      if (own_trans == TR_NONSEQ) begin
        incr_upd = (own_burst == BU_INCR);
        rem_upd  = burst_rem;
      end else if (rem_q != 4'd0) begin
        rem_upd = rem_q - 4'd1;
      end
    end
  end

  // Burst boundary detection: ownership may only move on these edges.
  assign switch_pt = hready && ((state_q == ST_IDLE) ||
                                (own_trans == TR_IDLE) ||
                                (!incr_upd && beat_acc && (rem_upd == 4'd0)) ||
                                (incr_upd && !own_req && (own_trans != TR_BUSY)));

  // Round-robin search; starting after the owner makes the owner the last candidate.
  assign start = (state_q == ST_OWN) ? wrap_inc(owner_q) : rr_ptr_q;

  // First requester at or after start, wrapping once around all channels.
  always_comb begin
    found  = 1'b0;
    winner = '0;
    cand   = 0;
    idx    = '0;
    for (int i = 0; i < CHANNEL_NUM; i++) begin
      cand = int'(start) + i;
      if (cand >= CHANNEL_NUM) cand = cand - CHANNEL_NUM;
      idx = ID_W'(cand);
      if (!found && hreq[idx]) begin
        found  = 1'b1;
        winner = idx;
      end
    end
  end

  // Next-state: data-phase select tracks accepted beats, ownership moves at switch points.
  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    rr_ptr_d   = rr_ptr_q;
    sel_addr_d = sel_addr_q;
    grant_d    = grant_q;
    rem_d      = rem_upd;
    incr_d     = incr_upd;
    sel_data_d = hready ? (beat_acc ? sel_addr_q : '0) : sel_data_q;
    if (switch_pt) begin
      rem_d  = 4'd0;
      incr_d = 1'b0;
      if (found) begin
        state_d    = ST_OWN;
        owner_d    = winner;
        sel_addr_d = CHANNEL_NUM'(1) << winner;
        grant_d    = 1'b1;
        rr_ptr_d   = wrap_inc(winner);
      end else begin
        state_d    = ST_IDLE;
        sel_addr_d = '0;
        grant_d    = 1'b0;
      end
    end
  end

  // State and registered outputs; reset abandons any burst in progress.
  always_ff @(posedge hclk) begin
    if (hreset) begin
      state_q    <= ST_IDLE;
      owner_q    <= '0;
      rr_ptr_q   <= '0;
      sel_addr_q <= '0;
      sel_data_q <= '0;
      grant_q    <= 1'b0;
      rem_q      <= 4'd0;
      incr_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      rr_ptr_q   <= rr_ptr_d;
      sel_addr_q <= sel_addr_d;
      sel_data_q <= sel_data_d;
      grant_q    <= grant_d;
      rem_q      <= rem_d;
      incr_q     <= incr_d;
    end
  end

  assign sel_addr    = sel_addr_q;
  assign sel_data    = sel_data_q;
  assign owner_id    = owner_q;
  assign grant_valid = grant_q;

endmodule

// File: tb/tb_ahb_slave_arbiter.sv
// Directed bench for ahb_slave_arbiter with a 2-channel and a 4-channel instance.
// Observed vectors are {sel_addr, sel_data, grant_valid, owner_id}, sampled 1 time unit after each edge.
// Expected values are hand-derived constants per edge.
module tb_ahb_slave_arbiter;

  logic hclk;
  logic hreset;
  logic hready;

  logic [1:0]      hreq2;
  logic [1:0][1:0] htrans2;
  logic [1:0][2:0] hburst2;
  logic [1:0]      sa2, sd2;
  logic            oid2;
  logic            gv2;

  logic [3:0]      hreq4;
  logic [3:0][1:0] htrans4;
  logic [3:0][2:0] hburst4;
  logic [3:0]      sa4, sd4;
  logic [1:0]      oid4;
  logic            gv4;

  logic [5:0]  obs2;
  logic [10:0] obs4;
  assign obs2 = {sa2, sd2, gv2, oid2};
  assign obs4 = {sa4, sd4, gv4, oid4};

  int n_cmp = 0;
  int n_err = 0;

  ahb_slave_arbiter #(.CHANNEL_NUM(2)) u2 (
    .hclk(hclk), .hreset(hreset), .hreq(hreq2), .htrans(htrans2), .hburst(hburst2),
    .hready(hready), .sel_addr(sa2), .sel_data(sd2), .owner_id(oid2), .grant_valid(gv2)
  );

  ahb_slave_arbiter #(.CHANNEL_NUM(4)) u4 (
    .hclk(hclk), .hreset(hreset), .hreq(hreq4), .htrans(htrans4), .hburst(hburst4),
    .hready(hready), .sel_addr(sa4), .sel_data(sd4), .owner_id(oid4), .grant_valid(gv4)
  );

  initial hclk = 1'b0;
  always #5 hclk = ~hclk;

  task automatic tick();
    @(posedge hclk);
    #1;
  endtask

  task automatic test_reset();
    hreset = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick();
      n_cmp++; if (obs2 !== 6'b000000) begin n_err++; $display("FAIL reset2_e%0d: got %b want %b", i, obs2, 6'b000000); end
      n_cmp++; if (obs4 !== 11'b0) begin n_err++; $display("FAIL reset4_e%0d: got %b want %b", i, obs4, 11'b0); end
    end
    hreset = 1'b0;
    tick();
    n_cmp++; if (obs2 !== 6'b000000) begin n_err++; $display("FAIL idle2: got %b want %b", obs2, 6'b000000); end
    n_cmp++; if (obs4 !== 11'b0) begin n_err++; $display("FAIL idle4: got %b want %b", obs4, 11'b0); end
  endtask

  task automatic test_basic_grant();
    hreq2 = 2'b01; htrans2[0] = 2'd2; hburst2[0] = 3'd0;
    tick();
    n_cmp++; if (obs2 !== 6'b010010) begin n_err++; $display("FAIL basic_grant: got %b want %b", obs2, 6'b010010); end
    tick();
    n_cmp++; if (obs2 !== 6'b010110) begin n_err++; $display("FAIL basic_data_lag: got %b want %b", obs2, 6'b010110); end
    hreq2 = 2'b00; htrans2[0] = 2'd0;
    tick();
    n_cmp++; if (obs2 !== 6'b000000) begin n_err++; $display("FAIL basic_release: got %b want %b", obs2, 6'b000000); end
  endtask

  task automatic test_burst_wait();
    hreq2 = 2'b01; htrans2[0] = 2'd2; hburst2[0] = 3'd3; htrans2[1] = 2'd2; hburst2[1] = 3'd0;
    tick();
    n_cmp++; if (obs2 !== 6'b010010) begin n_err++; $display("FAIL burst_grant: got %b want %b", obs2, 6'b010010); end
    hreq2 = 2'b11;
    tick();
    n_cmp++; if (obs2 !== 6'b010110) begin n_err++; $display("FAIL burst_beat1: got %b want %b", obs2, 6'b010110); end
    htrans2[0] = 2'd3; hready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      tick();
      n_cmp++; if (obs2 !== 6'b010110) begin n_err++; $display("FAIL burst_stall%0d: got %b want %b", i, obs2, 6'b010110); end
    end
    hready = 1'b1;
    tick();
    n_cmp++; if (obs2 !== 6'b010110) begin n_err++; $display("FAIL burst_beat2: got %b want %b", obs2, 6'b010110); end
    hreq2 = 2'b10;
    tick();
    n_cmp++; if (obs2 !== 6'b010110) begin n_err++; $display("FAIL burst_beat3_reqdrop: got %b want %b", obs2, 6'b010110); end
    tick();
    n_cmp++; if (obs2 !== 6'b100111) begin n_err++; $display("FAIL burst_handover: got %b want %b", obs2, 6'b100111); end
    htrans2[0] = 2'd0;
    tick();
    n_cmp++; if (obs2 !== 6'b101011) begin n_err++; $display("FAIL burst_regrant: got %b want %b", obs2, 6'b101011); end
    hreq2 = 2'b00; htrans2[1] = 2'd0;
    tick();
    n_cmp++; if (obs2 !== 6'b000001) begin n_err++; $display("FAIL burst_idle: got %b want %b", obs2, 6'b000001); end
  endtask

  task automatic test_incr_release();
    hreq2 = 2'b10; htrans2[1] = 2'd2; hburst2[1] = 3'd1; htrans2[0] = 2'd2; hburst2[0] = 3'd0;
    tick();
    n_cmp++; if (obs2 !== 6'b100011) begin n_err++; $display("FAIL incr_grant: got %b want %b", obs2, 6'b100011); end
    hreq2 = 2'b11;
    tick();
    n_cmp++; if (obs2 !== 6'b101011) begin n_err++; $display("FAIL incr_nonseq: got %b want %b", obs2, 6'b101011); end
    htrans2[1] = 2'd3;
    for (int i = 0; i < 5; i++) begin
      tick();
      n_cmp++; if (obs2 !== 6'b101011) begin n_err++; $display("FAIL incr_seq%0d: got %b want %b", i, obs2, 6'b101011); end
    end
    hreq2 = 2'b01; htrans2[1] = 2'd1;
    tick();
    n_cmp++; if (obs2 !== 6'b100011) begin n_err++; $display("FAIL incr_busy_hold: got %b want %b", obs2, 6'b100011); end
    htrans2[1] = 2'd3; hready = 1'b0;
    tick();
    n_cmp++; if (obs2 !== 6'b100011) begin n_err++; $display("FAIL incr_wait_hold: got %b want %b", obs2, 6'b100011); end
    hready = 1'b1;
    tick();
    n_cmp++; if (obs2 !== 6'b011010) begin n_err++; $display("FAIL incr_release: got %b want %b", obs2, 6'b011010); end
    htrans2[1] = 2'd0;
    tick();
    n_cmp++; if (obs2 !== 6'b010110) begin n_err++; $display("FAIL incr_next_owner: got %b want %b", obs2, 6'b010110); end
    hreq2 = 2'b00; htrans2[0] = 2'd0;
    tick();
    n_cmp++; if (obs2 !== 6'b000000) begin n_err++; $display("FAIL incr_idle: got %b want %b", obs2, 6'b000000); end
  endtask

  task automatic test_round_robin();
    logic [10:0] rr_exp [8];
    rr_exp[0] = {4'b0001, 4'b0000, 1'b1, 2'd0};
    rr_exp[1] = {4'b0010, 4'b0001, 1'b1, 2'd1};
    rr_exp[2] = {4'b0100, 4'b0010, 1'b1, 2'd2};
    rr_exp[3] = {4'b1000, 4'b0100, 1'b1, 2'd3};
    rr_exp[4] = {4'b0001, 4'b1000, 1'b1, 2'd0};
    rr_exp[5] = {4'b0010, 4'b0001, 1'b1, 2'd1};
    rr_exp[6] = {4'b1000, 4'b0010, 1'b1, 2'd3};
    rr_exp[7] = {4'b0010, 4'b1000, 1'b1, 2'd1};
    hreq4 = 4'b1111;
    for (int c = 0; c < 4; c++) begin
      htrans4[c] = 2'd2;
      hburst4[c] = 3'd0;
    end
    for (int i = 0; i < 8; i++) begin
      if (i == 6) hreq4 = 4'b1010;
      tick();
      n_cmp++; if (obs4 !== rr_exp[i]) begin n_err++; $display("FAIL rr_step%0d: got %b want %b", i, obs4, rr_exp[i]); end
    end
    hreq4 = 4'b0000;
    for (int c = 0; c < 4; c++) htrans4[c] = 2'd0;
    tick();
    n_cmp++; if (obs4 !== {4'b0000, 4'b0000, 1'b0, 2'd1}) begin n_err++; $display("FAIL rr_idle: got %b want %b", obs4, {4'b0000, 4'b0000, 1'b0, 2'd1}); end
  endtask

  task automatic test_reset_mid_burst();
    hreq2 = 2'b01; htrans2[0] = 2'd2; hburst2[0] = 3'd5; htrans2[1] = 2'd0; hburst2[1] = 3'd0;
    tick();
    n_cmp++; if (obs2 !== 6'b010010) begin n_err++; $display("FAIL rst_burst_grant: got %b want %b", obs2, 6'b010010); end
    tick();
    n_cmp++; if (obs2 !== 6'b010110) begin n_err++; $display("FAIL rst_burst_beat1: got %b want %b", obs2, 6'b010110); end
    htrans2[0] = 2'd3; hreset = 1'b1;
    tick();
    n_cmp++; if (obs2 !== 6'b000000) begin n_err++; $display("FAIL rst_mid_burst: got %b want %b", obs2, 6'b000000); end
    hreset = 1'b0; hreq2 = 2'b11;
    htrans2[0] = 2'd2; hburst2[0] = 3'd0; htrans2[1] = 2'd2; hburst2[1] = 3'd0;
    tick();
    n_cmp++; if (obs2 !== 6'b010010) begin n_err++; $display("FAIL rst_after_grant: got %b want %b", obs2, 6'b010010); end
    tick();
    n_cmp++; if (obs2 !== 6'b100111) begin n_err++; $display("FAIL rst_after_rotate: got %b want %b", obs2, 6'b100111); end
  endtask

  initial begin
    hreset = 1'b1; hready = 1'b1;
    hreq2 = '0; htrans2 = '0; hburst2 = '0;
    hreq4 = '0; htrans4 = '0; hburst4 = '0;
    test_reset();
    test_basic_grant();
    test_burst_wait();
    test_incr_release();
    test_round_robin();
    test_reset_mid_burst();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
